// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencing controller and its 4-bit counter core.
// No logic here; latency and backpressure are defined by the modules that import it.
package counter_seq_ctrl_pkg;

    localparam int CNT_W = 4;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Host-side bundle of the sequencer: configuration handshake, run controls and status.
// Master is the host/register block; slave is the controller.
interface counter_seq_ctrl_if;
    import counter_seq_ctrl_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_load;
    logic [CNT_W-1:0] cfg_limit;
    logic             cfg_dir;
    logic             cfg_reload;
    logic             start;
    logic             pause;
    logic             abort;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             tc_pulse;
    logic             done;

    modport master (
        output cfg_valid, cfg_load, cfg_limit, cfg_dir, cfg_reload, start, pause, abort,
        input  cfg_ready, count, busy, tc_pulse, done
    );

    modport slave (
        input  cfg_valid, cfg_load, cfg_limit, cfg_dir, cfg_reload, start, pause, abort,
        output cfg_ready, count, busy, tc_pulse, done
    );

endinterface

// File: rtl/counter_seq_ctrl_counter4_core.sv
// Loadable 4-bit up/down wrap-around counter register; ld has priority over en.
// One-cycle latency from ld/en to q; no backpressure.
module counter4_core
    import counter_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (en) begin
            q <= (dir == DIR_DOWN) ? q - 1'b1 : q + 1'b1;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Programmable one-shot/periodic timer sequencer around counter4_core; tc_pulse one cycle after count==limit.
// cfg_ready only in IDLE/DONE; cfg_valid is ignored (not queued) while a job is armed or running.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    counter_seq_ctrl_if.slave  bus
);

    state_t           state;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] limit_q;
    logic             dir_q;
    logic             reload_q;
    logic             tc_q;
    logic             done_q;

    logic             hs;
    logic             at_limit;
    logic             core_en;
    logic             core_ld;
    logic [CNT_W-1:0] core_ld_val;
    logic [CNT_W-1:0] cnt;

    assign bus.cfg_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign bus.busy      = (state == ST_ARMED) || (state == ST_RUN) || (state == ST_HOLD);
    assign hs            = bus.cfg_valid && bus.cfg_ready;
    assign at_limit      = (cnt == limit_q);

    // Counter control mirrors the FSM priorities below so count and state move on the same edge.
    always_comb begin
        core_en     = 1'b0;
        core_ld     = 1'b0;
        core_ld_val = load_q;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (state == ST_DONE && bus.abort) begin
                    core_ld     = 1'b1;
                    core_ld_val = '0;
                end else if (hs) begin
                    core_ld     = 1'b1;
                    core_ld_val = bus.cfg_load;
                end
            end
            ST_ARMED, ST_HOLD: begin
                if (bus.abort) begin
                    core_ld     = 1'b1;
                    core_ld_val = '0;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    core_ld     = 1'b1;
                    core_ld_val = '0;
                end else if (!bus.pause) begin
                    if (at_limit) begin
                        core_ld = (reload_q == MODE_RELOAD);
                    end else begin
                        core_en = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            load_q   <= '0;
            limit_q  <= '0;
            dir_q    <= DIR_UP;
            reload_q <= MODE_ONESHOT;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE && bus.abort) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b0;
                    end else if (hs) begin
                        load_q   <= bus.cfg_load;
                        limit_q  <= bus.cfg_limit;
                        dir_q    <= bus.cfg_dir;
                        reload_q <= bus.cfg_reload;
                        done_q   <= 1'b0;
                        state    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (bus.abort)      state <= ST_IDLE;
                    else if (bus.start) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (bus.pause) begin
                        state <= ST_HOLD;
                    end else if (at_limit) begin
                        tc_q <= 1'b1;
                        if (reload_q == MODE_ONESHOT) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.abort)      state <= ST_IDLE;
                    else if (!bus.pause) state <= ST_RUN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    counter4_core u_core (
        .clk    (clk),
        .rstn   (rstn),
        .en     (core_en),
        .dir    (dir_q),
        .ld     (core_ld),
        .ld_val (core_ld_val),
        .q      (cnt)
    );

    assign bus.count    = cnt;
    assign bus.tc_pulse = tc_q;
    assign bus.done     = done_q;

endmodule
